// File: rtl/mm_stream_bridge.sv
// Stream-to-BRAM feeder for the Montgomery multiplier: loads one operand set, starts the
// multiplier, then streams the s-word result back out with a last marker.
module mm_stream_bridge #(
   parameter int unsigned s           = 8,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        clock_i,
   input  logic        reset_n_i,
   input  logic [16:0] in_data_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output logic [16:0] out_data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic        out_last_o,
   output logic        bram_en_o,
   output logic        bram_we_o,
   output logic [31:0] bram_addr_o,
   output logic [16:0] bram_din_o,
   input  logic [16:0] bram_dout_i,
   output logic        mm_start_o,
   input  logic        mm_done_i,
   output logic        busy_o,
   output logic        error_o
);

   localparam int unsigned ADDR_W = $clog2(4 * s);

   localparam logic [ADDR_W-1:0] LastWordIdx = ADDR_W'(3 * s);
   localparam logic [ADDR_W-1:0] LastRdIdx   = ADDR_W'(s - 1);
   localparam logic [ADDR_W-1:0] ResBase     = ADDR_W'(s + 1);
   localparam bit                WdEn        = (TIMEOUT_CYC != 0);
   localparam logic [31:0]       WdLast      = WdEn ? 32'(TIMEOUT_CYC - 1) : 32'd0;

   typedef enum logic [2:0] {
      StLoad,
      StLastWr,
      StStart,
      StWait,
      StRdReq,
      StRdWait,
      StOut
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ld_cnt_q, ld_cnt_d;
   logic                wr_pend_q, wr_pend_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [16:0]         wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
   logic [31:0]         wd_cnt_q, wd_cnt_d;
   logic [16:0]         res_data_q, res_data_d;
   logic [ADDR_W-1:0]   addr;

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q    <= StLoad;
         ld_cnt_q   <= '0;
         wr_pend_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rd_idx_q   <= '0;
         wd_cnt_q   <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         wr_pend_q  <= wr_pend_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_idx_q   <= rd_idx_d;
         wd_cnt_q   <= wd_cnt_d;
         res_data_q <= res_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      wr_pend_d   = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_idx_d    = rd_idx_q;
      wd_cnt_d    = wd_cnt_q;
      res_data_d  = res_data_q;
      in_ready_o  = 1'b0;
      bram_en_o   = 1'b0;
      bram_we_o   = 1'b0;
      addr        = '0;
      bram_din_o  = '0;
      out_data_o  = '0;
      out_valid_o = 1'b0;
      out_last_o  = 1'b0;
      mm_start_o  = 1'b0;
      error_o     = 1'b0;

      // A word accepted on one edge is written on the following cycle (LOAD or LAST_WR only).
      if (wr_pend_q) begin
         bram_en_o  = 1'b1;
         bram_we_o  = 1'b1;
         addr       = wr_addr_q;
         bram_din_o = wr_data_q;
      end

      unique case (state_q)
         StLoad: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               wr_pend_d = 1'b1;
               wr_addr_d = ld_cnt_q;
               wr_data_d = in_data_i;
               if (ld_cnt_q == LastWordIdx) begin
                  ld_cnt_d = '0;
                  state_d  = StLastWr;
               end else begin
                  ld_cnt_d = ld_cnt_q + 1'b1;
               end
            end
         end
         StLastWr: begin
            state_d = StStart;
         end
         StStart: begin
            mm_start_o = 1'b1;
            wd_cnt_d   = '0;
            state_d    = StWait;
         end
         StWait: begin
            // The multiplier owns the BRAM here, so the port stays idle.
            if (mm_done_i) begin
               rd_idx_d = '0;
               state_d  = StRdReq;
            end else if (WdEn && (wd_cnt_q == WdLast)) begin
               error_o = 1'b1;
               state_d = StLoad;
            end else begin
               wd_cnt_d = wd_cnt_q + 32'd1;
            end
         end
         StRdReq: begin
            bram_en_o = 1'b1;
            addr      = ResBase + rd_idx_q;
            state_d   = StRdWait;
         end
         StRdWait: begin
            res_data_d = bram_dout_i;
            state_d    = StOut;
         end
         StOut: begin
            out_valid_o = 1'b1;
            out_data_o  = res_data_q;
            out_last_o  = (rd_idx_q == LastRdIdx);
            if (out_ready_i) begin
               if (rd_idx_q == LastRdIdx) begin
                  rd_idx_d = '0;
                  state_d  = StLoad;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
                  state_d  = StRdReq;
               end
            end
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   assign bram_addr_o = {{(32 - ADDR_W){1'b0}}, addr};
   assign busy_o      = !((state_q == StLoad) && (ld_cnt_q == '0));

endmodule

// File: tb/tb_mm_stream_bridge.sv
// Randomised bench for mm_stream_bridge: BRAM and multiplier models plus a transaction-level
// reference of the expected BRAM writes and result stream.
module tb_mm_stream_bridge;

   localparam int S  = 8;
   localparam int NW = 3 * S + 1;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [16:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [16:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic        bram_en;
   logic        bram_we;
   logic [31:0] bram_addr;
   logic [16:0] bram_din;
   logic [16:0] bram_dout = '0;
   logic        mm_start;
   logic        mm_done = 1'b0;
   logic        busy;
   logic        error;

   int checks = 0;
   int errors = 0;

   logic [16:0] mem     [0:31];
   logic [16:0] words   [0:NW-1];
   logic [16:0] res_img [0:S-1];
   logic        load_res = 1'b0;

   int          wa[$];
   logic [16:0] wdat[$];
   logic [16:0] got_data[$];
   logic        got_last[$];
   int cyc = 0, rd_cnt = 0, start_cnt = 0, err_cnt = 0;
   int start_cyc = 0, err_cyc = 0, hs_cyc = 0;
   bit stall_bad = 0;

   mm_stream_bridge #(.s(S), .TIMEOUT_CYC(TO)) dut (
      .clock_i(clk), .reset_n_i(rst_n),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_last_o(out_last),
      .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
      .bram_din_o(bram_din), .bram_dout_i(bram_dout),
      .mm_start_o(mm_start), .mm_done_i(mm_done),
      .busy_o(busy), .error_o(error)
   );

   always #5 clk = ~clk;

   // BRAM port B model; load_res stands in for the multiplier writing its result.
   always @(posedge clk) begin
      if (load_res) for (int i = 0; i < S; i++) mem[S + 1 + i] <= res_img[i];
      if (bram_en && bram_we) mem[bram_addr[4:0]] <= bram_din;
      if (bram_en && !bram_we) bram_dout <= mem[bram_addr[4:0]];
   end

   always @(posedge clk) begin
      cyc++;
      if (rst_n) begin
         if (bram_en && bram_we) begin
            wa.push_back(int'(bram_addr));
            wdat.push_back(bram_din);
         end
         if (bram_en && !bram_we) rd_cnt++;
         if (mm_start) begin start_cnt++; start_cyc = cyc; end
         if (error) begin err_cnt++; err_cyc = cyc; end
         if (in_valid && in_ready) hs_cyc = cyc;
      end
   end

   task automatic clear_mon();
      wa.delete(); wdat.delete(); got_data.delete(); got_last.delete();
      rd_cnt = 0; start_cnt = 0; err_cnt = 0; stall_bad = 0;
   endtask

   // mode 0: dense, 1: valid every other cycle, 2: random gaps
   task automatic drive_words(input int mode);
      int i = 0;
      int g = 0;
      bit v;
      while (i < NW && g < 2000) begin
         @(negedge clk);
         g++;
         if (mode == 1) v = g[0];
         else if (mode == 2) v = ($urandom_range(0, 3) != 0);
         else v = 1'b1;
         in_valid = v;
         in_data  = v ? words[i] : 17'($urandom);
         if (v && in_ready) i++;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic mm_model(input int delay, input bit give_done);
      int g = 0;
      do begin @(negedge clk); g++; end while (mm_start !== 1'b1 && g < 3000);
      if (mm_start === 1'b1 && give_done) begin
         repeat (delay) @(negedge clk);
         load_res = 1'b1;
         mm_done  = 1'b1;
         @(negedge clk);
         load_res = 1'b0;
         mm_done  = 1'b0;
      end
   endtask

   task automatic sink(input int stall_at, input int stall_len, input int abort_at,
                       input bit rnd);
      int n = 0;
      int g = 0;
      int held = 0;
      logic [16:0] hold_d = '0;
      bit r;
      while (n < S && n != abort_at && g < 3000) begin
         @(negedge clk);
         g++;
         if (n == stall_at && held > 0 && (!out_valid || out_data !== hold_d)) stall_bad = 1;
         if (out_valid && n == stall_at && held < stall_len) begin
            hold_d = out_data;
            held++;
            out_ready = 1'b0;
         end else begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (out_valid && r) begin
               got_data.push_back(out_data);
               got_last.push_back(out_last);
               n++;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (bram_en !== 1'b0) begin errors++; $display("FAIL reset_bram_en got %b exp 0", bram_en); end
      checks++; if (busy !== 1'b0 || error !== 1'b0 || mm_start !== 1'b0) begin
         errors++; $display("FAIL reset_flags got busy=%b err=%b start=%b exp 0", busy, error, mm_start);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_load_start();
      for (int i = 0; i < NW; i++) words[i] = 17'(i + 1);
      for (int i = 0; i < S; i++) res_img[i] = 17'($urandom);
      clear_mon();
      fork
         drive_words(0);
         mm_model(10, 1'b1);
         sink(-1, 0, -1, 1'b0);
      join
      @(negedge clk);
      checks++; if (wa.size() != NW) begin errors++; $display("FAIL load_write_count got %0d exp %0d", wa.size(), NW); end
      for (int i = 0; i < NW && i < wa.size(); i++) begin
         checks++;
         if (wa[i] != i || wdat[i] !== words[i]) begin
            errors++; $display("FAIL load_write_%0d got addr %0d data %h exp addr %0d data %h", i, wa[i], wdat[i], i, words[i]);
         end
      end
      checks++; if (start_cnt != 1) begin errors++; $display("FAIL start_count got %0d exp 1", start_cnt); end
      checks++; if (start_cyc - hs_cyc != 2) begin errors++; $display("FAIL start_latency got %0d exp 2", start_cyc - hs_cyc); end
      checks++; if (got_data.size() != S) begin errors++; $display("FAIL load_result_count got %0d exp %0d", got_data.size(), S); end
      for (int i = 0; i < S && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== res_img[i]) begin errors++; $display("FAIL load_result_%0d got %h exp %h", i, got_data[i], res_img[i]); end
      end
   endtask

   task automatic test_readback();
      for (int i = 0; i < NW; i++) words[i] = 17'($urandom);
      for (int i = 0; i < S; i++) res_img[i] = 17'h1AAAA + 17'(i);
      clear_mon();
      fork
         drive_words(2);
         mm_model($urandom_range(1, 12), 1'b1);
         sink(-1, 0, -1, 1'b0);
      join
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (got_data.size() != S) begin errors++; $display("FAIL rb_count got %0d exp %0d", got_data.size(), S); end
      for (int i = 0; i < S && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== res_img[i] || got_last[i] !== (i == S - 1)) begin
            errors++; $display("FAIL rb_word_%0d got %h last %b exp %h last %b", i, got_data[i], got_last[i], res_img[i], i == S - 1);
         end
      end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL rb_after got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
      end
      checks++; if (rd_cnt != S) begin errors++; $display("FAIL rb_reads got %0d exp %0d", rd_cnt, S); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < NW; i++) words[i] = 17'($urandom);
      for (int i = 0; i < S; i++) res_img[i] = 17'($urandom);
      clear_mon();
      fork
         drive_words(0);
         mm_model(4, 1'b1);
         sink(3, 5, -1, 1'b0);
      join
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (stall_bad) begin errors++; $display("FAIL stall_stable got changed exp held"); end
      checks++; if (rd_cnt != S) begin errors++; $display("FAIL stall_reads got %0d exp %0d", rd_cnt, S); end
      checks++; if (got_data.size() != S) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_data.size(), S); end
      for (int i = 0; i < S && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== res_img[i]) begin errors++; $display("FAIL stall_word_%0d got %h exp %h", i, got_data[i], res_img[i]); end
      end
   endtask

   task automatic test_gappy_load();
      for (int i = 0; i < NW; i++) words[i] = 17'($urandom);
      for (int i = 0; i < S; i++) res_img[i] = 17'($urandom);
      clear_mon();
      fork
         drive_words(1);
         mm_model(2, 1'b1);
         sink(-1, 0, -1, 1'b1);
      join
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (wa.size() != NW) begin errors++; $display("FAIL gap_write_count got %0d exp %0d", wa.size(), NW); end
      for (int i = 0; i < NW && i < wa.size(); i++) begin
         checks++;
         if (wa[i] != i || wdat[i] !== words[i]) begin
            errors++; $display("FAIL gap_write_%0d got addr %0d data %h exp addr %0d data %h", i, wa[i], wdat[i], i, words[i]);
         end
      end
      for (int i = 0; i < S && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== res_img[i]) begin errors++; $display("FAIL gap_word_%0d got %h exp %h", i, got_data[i], res_img[i]); end
      end
   endtask

   task automatic test_timeout();
      int g = 0;
      for (int i = 0; i < NW; i++) words[i] = 17'($urandom);
      clear_mon();
      fork
         drive_words(0);
         mm_model(0, 1'b0);
      join
      while (err_cnt == 0 && g < 60) begin @(negedge clk); g++; end
      checks++; if (err_cnt == 0) begin errors++; $display("FAIL to_seen got no error pulse exp pulse"); end
      checks++; if (err_cyc - start_cyc != TO) begin errors++; $display("FAIL to_latency got %0d exp %0d", err_cyc - start_cyc, TO); end
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL to_back_to_load got in_ready=%b busy=%b exp 1 0", in_ready, busy);
      end
      mm_done = 1'b1;
      @(negedge clk);
      mm_done = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (err_cnt != 1) begin errors++; $display("FAIL to_pulse_count got %0d exp 1", err_cnt); end
      checks++; if (rd_cnt != 0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL to_no_reads got reads=%0d out_valid=%b exp 0 0", rd_cnt, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      int g = 0;
      for (int i = 0; i < NW; i++) words[i] = 17'($urandom);
      for (int i = 0; i < S; i++) res_img[i] = 17'($urandom);
      clear_mon();
      fork
         drive_words(0);
         mm_model(3, 1'b1);
         sink(-1, 0, 4, 1'b0);
      join
      do begin @(negedge clk); out_ready = 1'b0; g++; end while (out_valid !== 1'b1 && g < 20);
      checks++; if (got_data.size() != 4) begin errors++; $display("FAIL rm_pre_count got %0d exp 4", got_data.size()); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rm_after_reset got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
      end
      rst_n = 1'b1;
      for (int i = 0; i < NW; i++) words[i] = 17'($urandom);
      for (int i = 0; i < S; i++) res_img[i] = 17'($urandom);
      clear_mon();
      fork
         drive_words(2);
         mm_model($urandom_range(1, 12), 1'b1);
         sink(-1, 0, -1, 1'b1);
      join
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (wa.size() != NW || start_cnt != 1) begin
         errors++; $display("FAIL rm_reload got writes=%0d starts=%0d exp %0d 1", wa.size(), start_cnt, NW);
      end
      for (int i = 0; i < S && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== res_img[i] || got_last[i] !== (i == S - 1)) begin
            errors++; $display("FAIL rm_word_%0d got %h last %b exp %h", i, got_data[i], got_last[i], res_img[i]);
         end
      end
      checks++; if (got_data.size() != S) begin errors++; $display("FAIL rm_count got %0d exp %0d", got_data.size(), S); end
   endtask

   initial begin
      test_reset();
      test_load_start();
      test_readback();
      test_stall();
      test_gappy_load();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got no finish exp finish");
      $fatal(1, "bench timeout");
   end

endmodule
